cr_kme_fifo_serializer: RTL and testbench



---
 rtl/cr_kme_ser_pkg.sv | 16 +
 rtl/cr_kme_ser_beat_mux.sv | 29 ++
 rtl/cr_kme_fifo_serializer.sv | 90 +++++++++
 tb/tb_cr_kme_fifo_serializer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cr_kme_ser_pkg.sv
// Shared types and default widths for the KME FIFO beat serializer.
package cr_kme_ser_pkg;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_e;

    localparam int CR_KME_SER_DATA_SIZE = 128;
    localparam int CR_KME_SER_BEAT_SIZE = 32;

    function automatic int ser_num_beats(input int data_size, input int beat_size);
        return data_size / beat_size;
    endfunction

endpackage

// File: rtl/cr_kme_ser_beat_mux.sv
// Combinational beat select from the held entry, LSB beat first.
// Computes even parity of the selected beat when CR_KME_SER_PARITY_EN is defined.
module cr_kme_ser_beat_mux
    import cr_kme_ser_pkg::*;
#(
    parameter int DATA_SIZE = CR_KME_SER_DATA_SIZE,
    parameter int BEAT_SIZE = CR_KME_SER_BEAT_SIZE,
    parameter int NUM_BEATS = ser_num_beats(DATA_SIZE, BEAT_SIZE),
    parameter int IDX_W     = $clog2(NUM_BEATS)
) (
    input  logic [DATA_SIZE-1:0] hold_q,
    input  logic [IDX_W-1:0]     beat_idx,
    output logic [BEAT_SIZE-1:0] beat_data
`ifdef CR_KME_SER_PARITY_EN
    ,
    output logic                 beat_parity
`endif
);

    logic [NUM_BEATS-1:0][BEAT_SIZE-1:0] beats;

    assign beats     = hold_q;
    assign beat_data = beats[beat_idx];

`ifdef CR_KME_SER_PARITY_EN
    assign beat_parity = ^beat_data;
`endif

endmodule

// File: rtl/cr_kme_fifo_serializer.sv
// Pops 128-bit entries from the KME FIFO and streams them as NUM_BEATS narrow beats.
// Optional even-parity output enabled by defining CR_KME_SER_PARITY_EN.
module cr_kme_fifo_serializer
    import cr_kme_ser_pkg::*;
#(
    parameter int DATA_SIZE = CR_KME_SER_DATA_SIZE,
    parameter int BEAT_SIZE = CR_KME_SER_BEAT_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] fifo_out,
    input  logic                 fifo_out_valid,
    output logic                 fifo_out_ack,
    input  logic                 flush,
    output logic [BEAT_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 busy
`ifdef CR_KME_SER_PARITY_EN
    ,
    output logic                 out_parity
`endif
);

    localparam int NUM_BEATS = ser_num_beats(DATA_SIZE, BEAT_SIZE);
    localparam int IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    if ((DATA_SIZE % BEAT_SIZE) != 0 || NUM_BEATS < 2) begin : g_bad_cfg
        $error("cr_kme_fifo_serializer: BEAT_SIZE must divide DATA_SIZE into at least 2 beats");
    end

    ser_state_e           state;
    logic [DATA_SIZE-1:0] hold_q;
    logic [IDX_W-1:0]     beat_idx;
    logic                 accept;
    logic                 last_acc;
    logic                 pop;

    assign busy      = (state == SER_SEND);
    assign out_valid = busy;
    assign out_first = busy && (beat_idx == '0);
    assign out_last  = busy && (beat_idx == LAST_IDX);

    assign accept   = out_valid && out_ready;
    assign last_acc = accept && out_last;

    // Refill on the last accepted beat keeps a continuously valid FIFO gap-free.
    assign fifo_out_ack = !rst && !flush && fifo_out_valid &&
                          ((state == SER_IDLE) || last_acc);
    assign pop          = fifo_out_valid && fifo_out_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SER_IDLE;
            beat_idx <= '0;
            hold_q   <= '0;
        end else if (flush) begin
            state    <= SER_IDLE;
            beat_idx <= '0;
        end else if (pop) begin
            state    <= SER_SEND;
            beat_idx <= '0;
            hold_q   <= fifo_out;
        end else if (last_acc) begin
            state    <= SER_IDLE;
            beat_idx <= '0;
        end else if (accept) begin
            beat_idx <= beat_idx + IDX_W'(1);
        end
    end

    cr_kme_ser_beat_mux #(
        .DATA_SIZE (DATA_SIZE),
        .BEAT_SIZE (BEAT_SIZE),
        .NUM_BEATS (NUM_BEATS),
        .IDX_W     (IDX_W)
    ) u_beat_mux (
        .hold_q      (hold_q),
        .beat_idx    (beat_idx),
        .beat_data   (out_data)
`ifdef CR_KME_SER_PARITY_EN
        ,
        .beat_parity (out_parity)
`endif
    );

endmodule

// File: tb/tb_cr_kme_fifo_serializer.sv
// Scoreboard bench for cr_kme_fifo_serializer: directed scenarios followed by random traffic.
module tb_cr_kme_fifo_serializer;

    localparam int DS = 128;
    localparam int BS = 32;
    localparam int NB = DS / BS;

    typedef struct packed {
        logic [BS-1:0] data;
        logic          first;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_out_valid = 1'b0;
    logic [DS-1:0] fifo_out = '0;
    logic          fifo_out_ack;
    logic [BS-1:0] out_data;
    logic          out_valid;
    logic          out_first;
    logic          out_last;
    logic          busy;
`ifdef CR_KME_SER_PARITY_EN
    logic          out_parity;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [DS-1:0] fifo_q[$];
    beat_t         sb_q[$];
    bit            hold_zero = 1'b1;

    always #5 clk = ~clk;

    cr_kme_fifo_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_out       (fifo_out),
        .fifo_out_valid (fifo_out_valid),
        .fifo_out_ack   (fifo_out_ack),
        .flush          (flush),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_first      (out_first),
        .out_last       (out_last),
        .busy           (busy)
`ifdef CR_KME_SER_PARITY_EN
        ,
        .out_parity     (out_parity)
`endif
    );

    task automatic chk(input string name, input logic [DS-1:0] act, input logic [DS-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t: wait bound expired", name, $time);
    endtask

    // Reference model: the held entry is a queue of outstanding beats.
    task automatic mon();
        beat_t         b;
        logic [DS-1:0] e;
        bit            exp_valid;
        bit            acc;
        bit            last_acc;
        bit            exp_ack;
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_first", out_first, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_fifo_out_ack", fifo_out_ack, 0);
`ifdef CR_KME_SER_PARITY_EN
            chk("rst_out_parity", out_parity, 0);
`endif
            sb_q.delete();
            hold_zero = 1'b1;
            return;
        end
        exp_valid = (sb_q.size() > 0);
        b = '0;
        chk("out_valid", out_valid, exp_valid);
        chk("busy", busy, exp_valid);
        if (exp_valid) begin
            b = sb_q[0];
            chk("out_data", out_data, b.data);
            chk("out_first", out_first, b.first);
            chk("out_last", out_last, b.last);
`ifdef CR_KME_SER_PARITY_EN
            chk("out_parity", out_parity, ^b.data);
`endif
        end else if (hold_zero) begin
            chk("idle_out_data", out_data, 0);
        end
        acc      = exp_valid && out_ready;
        last_acc = acc && b.last;
        exp_ack  = !flush && fifo_out_valid && (!exp_valid || last_acc);
        chk("fifo_out_ack", fifo_out_ack, exp_ack);
        if (acc) void'(sb_q.pop_front());
        if (flush) begin
            sb_q.delete();
        end else if (exp_ack) begin
            e = fifo_q.pop_front();
            for (int k = 0; k < NB; k++)
                sb_q.push_back('{data: e[k*BS +: BS], first: (k == 0), last: (k == NB-1)});
            hold_zero = 1'b0;
        end
    endtask

    always @(negedge clk) mon();

    task automatic refresh();
        fifo_out_valid = (fifo_q.size() > 0);
        fifo_out       = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        refresh();
    endtask

    task automatic push(input logic [DS-1:0] e);
        fifo_q.push_back(e);
        refresh();
    endtask

    task automatic wait_remaining(input int n, input string name);
        int t = 0;
        while (sb_q.size() != n && t < 100) begin
            cyc();
            t++;
        end
        if (sb_q.size() != n) fail_bound(name);
    endtask

    task automatic drain(input string name);
        int t = 0;
        flush = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
        while ((fifo_q.size() != 0 || sb_q.size() != 0) && t < 200) begin
            cyc();
            t++;
        end
        if (fifo_q.size() != 0 || sb_q.size() != 0) fail_bound(name);
        cyc();
        cyc();
    endtask

    initial begin
        refresh();
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // Single entry with the LSB beat first.
        out_ready = 1'b1;
        push(128'h4444_4444_3333_3333_2222_2222_1111_1111);
        drain("single_drain");

        // Three entries back to back: 12 gap-free beats.
        push(128'hA3A3_A3A3_A2A2_A2A2_A1A1_A1A1_A0A0_A0A0);
        push(128'hB3B3_B3B3_B2B2_B2B2_B1B1_B1B1_B0B0_B0B0);
        push(128'hC3C3_C3C3_C2C2_C2C2_C1C1_C1C1_C0C0_C0C0);
        drain("b2b_drain");

        // Backpressure while beat 2 is presented, next entry waiting.
        push(128'hD3D3_D3D3_D2D2_D2D2_D1D1_D1D1_D0D0_D0D0);
        push(128'hE3E3_E3E3_E2E2_E2E2_E1E1_E1E1_E0E0_E0E0);
        wait_remaining(2, "bp_wait_beat2");
        out_ready = 1'b0;
        repeat (5) cyc();
        drain("bp_drain");

        // Flush during beat 1 with the FIFO still valid.
        push(128'hF3F3_F3F3_F2F2_F2F2_F1F1_F1F1_F0F0_F0F0);
        push(128'h1313_1313_1212_1212_1111_1111_1010_1010);
        wait_remaining(3, "flush_wait_beat1");
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drain("flush_drain");

        // Reset in the middle of an entry.
        push(128'h5353_5353_5252_5252_5151_5151_5050_5050);
        push(128'h6363_6363_6262_6262_6161_6161_6060_6060);
        wait_remaining(2, "rst_wait_beat2");
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        drain("rst_drain");

        // Parity corner beats: 7 (odd) and 3 (even).
        push(128'h0000_0000_FFFF_FFFF_0000_0003_0000_0007);
        drain("parity_drain");

        // Random traffic with backpressure, flushes and occasional resets.
        repeat (800) begin
            cyc();
            if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0)
                push({$urandom, $urandom, $urandom, $urandom});
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 99) == 0);
        end
        drain("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
